// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one shared full_adder cell adds two WIDTH-bit
// operands LSB first, one bit per clock, bracketed by a start/busy/done handshake.

module full_adder (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic Y,
    output logic cout
);
    assign Y    = A ^ B ^ cin;
    assign cout = (A & B) | (cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // A single-bit counter still works for WIDTH=1 because the terminal value is 0.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r,  state_nxt_s;
    logic [WIDTH-1:0] a_sr_r,   a_sr_nxt_s;
    logic [WIDTH-1:0] b_sr_r,   b_sr_nxt_s;
    logic [WIDTH-1:0] psum_r,   psum_nxt_s;
    logic [WIDTH-1:0] sum_r,    sum_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic             carry_r,  carry_nxt_s;
    logic             cout_r,   cout_nxt_s;
    logic             busy_r,   busy_nxt_s;
    logic             done_r,   done_nxt_s;
    logic             fa_y_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] psum_shift_s;

    full_adder u_fa (
        .A    (a_sr_r[0]),
        .B    (b_sr_r[0]),
        .cin  (carry_r),
        .Y    (fa_y_s),
        .cout (fa_cout_s)
    );

    // New bit enters at the MSB; after WIDTH shifts the LSB sits in bit 0.
    assign psum_shift_s = WIDTH'({fa_y_s, psum_r} >> 1);

    // Next-state, datapath and output decode.
    always_comb begin
        state_nxt_s = state_r;
        a_sr_nxt_s  = a_sr_r;
        b_sr_nxt_s  = b_sr_r;
        psum_nxt_s  = psum_r;
        sum_nxt_s   = sum_r;
        cnt_nxt_s   = cnt_r;
        carry_nxt_s = carry_r;
        cout_nxt_s  = cout_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    a_sr_nxt_s  = a;
                    b_sr_nxt_s  = b;
                    carry_nxt_s = cin;
                    psum_nxt_s  = '0;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sr_nxt_s  = a_sr_r >> 1;
                b_sr_nxt_s  = b_sr_r >> 1;
                psum_nxt_s  = psum_shift_s;
                carry_nxt_s = fa_cout_s;
                cnt_nxt_s   = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_CNT) begin
                    sum_nxt_s   = psum_shift_s;
                    cout_nxt_s  = fa_cout_s;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_RUN);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            a_sr_r  <= '0;
            b_sr_r  <= '0;
            psum_r  <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_sr_r  <= a_sr_nxt_s;
            b_sr_r  <= b_sr_nxt_s;
            psum_r  <= psum_nxt_s;
            sum_r   <= sum_nxt_s;
            cnt_r   <= cnt_nxt_s;
            carry_r <= carry_nxt_s;
            cout_r  <= cout_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a WIDTH=4 instance for directed
// handshake/boundary cases and a WIDTH=3 instance for exhaustive arithmetic.

module tb_serial_adder_ctrl;

    logic       clk_s = 1'b0;
    logic       reset_s;
    logic       start4_s, cin4_s, busy4_s, done4_s, cout4_s;
    logic [3:0] a4_s, b4_s, sum4_s;
    logic       start3_s, cin3_s, busy3_s, done3_s, cout3_s;
    logic [2:0] a3_s, b3_s, sum3_s;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] q4[$];
    logic [3:0] q3[$];
    logic [4:0] last4_s;

    always #5 clk_s = ~clk_s;

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk_s), .reset(reset_s), .start(start4_s), .a(a4_s), .b(b4_s),
        .cin(cin4_s), .busy(busy4_s), .done(done4_s), .sum(sum4_s), .cout(cout4_s)
    );

    serial_adder_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk_s), .reset(reset_s), .start(start3_s), .a(a3_s), .b(b3_s),
        .cin(cin3_s), .busy(busy3_s), .done(done3_s), .sum(sum3_s), .cout(cout3_s)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk_s) begin
        if (done4_s === 1'b1) begin
            check_val("q4_pending", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) check_val("res4", {cout4_s, sum4_s}, q4.pop_front());
        end
        if (done3_s === 1'b1) begin
            check_val("q3_pending", 32'(q3.size() > 0), 32'd1);
            if (q3.size() > 0) check_val("res3", {cout3_s, sum3_s}, q3.pop_front());
        end
    end

    // One WIDTH=4 addition with cycle-accurate handshake checks; disturb
    // scrambles operands and pulses start while the operation is in flight.
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic c, input bit disturb);
        logic [4:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        a4_s = a; b4_s = b; cin4_s = c; start4_s = 1'b1;
        q4.push_back(exp);
        tick();
        start4_s = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check_val("busy4_run", busy4_s, 1'b1);
            check_val("done4_run", done4_s, 1'b0);
            check_val("sum4_hold", {cout4_s, sum4_s}, last4_s);
            if (disturb) begin
                a4_s = ~a4_s; b4_s = b4_s + 4'd1; cin4_s = ~cin4_s; start4_s = i[0];
            end
            tick();
        end
        check_val("done4_pulse", done4_s, 1'b1);
        check_val("busy4_done", busy4_s, 1'b0);
        if (disturb) start4_s = 1'b1;
        tick();
        start4_s = 1'b0;
        check_val("done4_after", done4_s, 1'b0);
        check_val("busy4_after", busy4_s, 1'b0);
        check_val("res4_held", {cout4_s, sum4_s}, exp);
        last4_s = exp;
        if (disturb) begin
            tick();
            check_val("busy4_no_extra", busy4_s, 1'b0);
            check_val("res4_held2", {cout4_s, sum4_s}, exp);
        end
    endtask

    initial begin
        reset_s = 1'b1;
        start4_s = 1'b0; a4_s = 4'd0; b4_s = 4'd0; cin4_s = 1'b0;
        start3_s = 1'b0; a3_s = 3'd0; b3_s = 3'd0; cin3_s = 1'b0;
        last4_s = 5'd0;
        tick();
        tick();
        check_val("rst_busy4", busy4_s, 1'b0);
        check_val("rst_done4", done4_s, 1'b0);
        check_val("rst_res4", {cout4_s, sum4_s}, 5'd0);
        check_val("rst_busy3", busy3_s, 1'b0);
        check_val("rst_res3", {cout3_s, sum3_s}, 4'd0);
        reset_s = 1'b0;

        do_op4(4'b0101, 4'b0011, 1'b0, 1'b0);
        do_op4(4'b1111, 4'b0001, 1'b0, 1'b0);
        do_op4(4'b0111, 4'b1000, 1'b1, 1'b0);

        // Start held high: one operation every six cycles.
        a4_s = 4'b0010; b4_s = 4'b0011; cin4_s = 1'b0; start4_s = 1'b1;
        for (int k = 0; k < 3; k++) q4.push_back(5'b00101);
        for (int cyc = 1; cyc <= 17; cyc++) begin
            tick();
            check_val("b2b_done", done4_s, 32'((cyc % 6) == 5));
            check_val("b2b_busy", busy4_s, 32'(((cyc % 6) >= 1) && ((cyc % 6) <= 4)));
            if (cyc == 17) start4_s = 1'b0;
        end
        tick();
        check_val("b2b_idle", busy4_s, 1'b0);
        check_val("b2b_res", {cout4_s, sum4_s}, 5'b00101);
        last4_s = 5'b00101;

        do_op4(4'b0110, 4'b0011, 1'b0, 1'b1);

        // Reset in the second RUN cycle abandons the add.
        a4_s = 4'b1111; b4_s = 4'b1111; cin4_s = 1'b0; start4_s = 1'b1;
        tick();
        start4_s = 1'b0;
        tick();
        reset_s = 1'b1;
        tick();
        reset_s = 1'b0;
        check_val("mid_rst_busy", busy4_s, 1'b0);
        check_val("mid_rst_done", done4_s, 1'b0);
        check_val("mid_rst_res", {cout4_s, sum4_s}, 5'd0);
        last4_s = 5'd0;
        tick();
        check_val("mid_rst_idle", busy4_s, 1'b0);

        // Reset and start together: start must not be accepted.
        reset_s = 1'b1; start4_s = 1'b1; a4_s = 4'b0011; b4_s = 4'b0100;
        tick();
        reset_s = 1'b0; start4_s = 1'b0;
        check_val("rst_start_busy", busy4_s, 1'b0);
        tick();
        check_val("rst_start_idle", busy4_s, 1'b0);

        do_op4(4'b0001, 4'b0001, 1'b0, 1'b0);

        // Exhaustive WIDTH=3 sweep.
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a3_s = 3'(ai); b3_s = 3'(bi); cin3_s = 1'(ci); start3_s = 1'b1;
                    q3.push_back(4'(ai + bi + ci));
                    tick();
                    start3_s = 1'b0;
                    for (int k = 1; k <= 3; k++) begin
                        check_val("busy3_run", busy3_s, 1'b1);
                        check_val("done3_run", done3_s, 1'b0);
                        tick();
                    end
                    check_val("done3_pulse", done3_s, 1'b1);
                    check_val("busy3_done", busy3_s, 1'b0);
                    tick();
                    check_val("done3_after", done3_s, 1'b0);
                end
            end
        end

        tick();
        check_val("q4_drained", 32'(q4.size()), 32'd0);
        check_val("q3_drained", 32'(q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer. It time-shares a single full_adder cell (the team's existing one-bit cell: A, B, cin, Y, cout) to add two WIDTH-bit operands, one bit per clock, LSB first.
- A start/busy/done handshake brackets each operation.
- It replaces a WIDTH-long ripple chain of full_adder instances when area matters more than latency. It sits between switch-driven operand inputs and LED/result logic in the top level.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted-start edge.
- b  input  WIDTH  operand B; captured on the accepted-start edge.
- cin  input  1  carry-in; captured on the accepted-start edge.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse; sum and cout are valid and final.
- sum  output  WIDTH  registered result, held until the next accepted start.
- cout  output  1  registered final carry-out, held like sum.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
  - With reset high at a rising edge: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, internal operand/carry/partial-sum registers=0.
  - Reset has priority over all other inputs.
- Datapath:
  - Exactly one full_adder instance.
  - A input = bit 0 of the A shift register; B input = bit 0 of the B shift register; cin input = the carry flop.
  - Each RUN cycle:
    - A and B shift registers shift right by 1.
    - The full_adder Y output shifts into the MSB of the partial-sum shift register, which shifts right.
    - The carry flop loads the full_adder cout.
    - The counter increments.
  - After WIDTH RUN cycles, the partial-sum register holds the sum with bit 0 = LSB.
- FSM states: IDLE, RUN, DONE (encoding free).
  - IDLE: busy=0, done=0. If start=1: load a, b into the shift registers, carry flop<=cin, partial sum<=0, counter<=0, next=RUN. Otherwise stay in IDLE.
  - RUN: busy=1, done=0. Process one bit per cycle.
    - While counter==WIDTH-1: sum<=partial sum including this bit, cout<=full_adder cout, next=DONE.
    - Otherwise: stay in RUN.
  - DONE: busy=0, done=1 for exactly this one cycle; next=IDLE unconditionally.
- Latency:
  - start sampled high at edge E0.
  - busy is high for cycles 1..WIDTH.
  - done is high in cycle WIDTH+1.
  - Throughput: one addition per WIDTH+2 cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow condition beyond cout.
- Boundary conditions:
  - start in RUN or DONE: ignored, with no queuing. A start held high is accepted in the next IDLE cycle.
  - Changes on a, b, cin after the accepted-start edge do not affect the operation in flight.
  - sum and cout change only on the RUN->DONE edge or on reset. During RUN they keep the previous result.
  - reset asserted mid-RUN: operation abandoned, no done pulse, outputs cleared as above.
  - reset asserted in the same cycle as start: reset wins, and start is not accepted.
  - WIDTH=1: exactly one RUN cycle; done in cycle 2.
  - Counter width is clog2(WIDTH) bits, minimum 1. The counter must not wrap before the terminal compare.

Test Plan:
- WIDTH=4, a=0101, b=0011, cin=0, start pulsed at E0 -> busy high cycles 1-4; done high only in cycle 5; sum=1000, cout=0; values held after done.
- WIDTH=4, a=1111, b=0001, cin=0 -> sum=0000, cout=1. Then a=0111, b=1000, cin=1 -> sum=0000, cout=1.
- Back-to-back: start held high continuously with a=0010, b=0011, cin=0 -> done pulses in cycles 5, 11, 17…; sum=0101 each time.
- Operand change: a/b/cin toggled during RUN, and start pulses during RUN and DONE -> result unaffected; the extra starts produce no additional operation.
- Reset mid-RUN in cycle 2 of an add of 1111+1111 -> next cycle busy=0, done=0, sum=0, cout=0. A fresh start afterwards computes 0001+0001 -> sum=0010, cout=0.
- Exhaustive: WIDTH=3, all a, b, cin combinations (128) -> {cout,sum} equals a+b+cin; done exactly once per operation, 4 cycles after start.
